coherent_mem_arbiter: RTL and testbench
=======================================

Name: coherent_mem_arbiter

Overview:
- Parametrised N-requester arbiter between per-cache coherency units and the single memory-controller bus port.
- Generalises the fixed two-requester (I/D, one hart) arrangement to NUM_REQ requesters.
- Selectable round-robin or fixed-priority arbitration.
- Block-burst grant locking, so a cache line fill/writeback of BLOCK_SIZE words is never interleaved with another requester's traffic.

Parameters:
- NUM_REQ, 4: number of requesters (≥2); index 0 is highest priority in fixed mode.
- BLOCK_SIZE, 2: words per burst lock (power of 2, ≥1).
- ARB_MODE, 0: 0 = round-robin, 1 = fixed priority.
- IDLE_LIMIT, 3: consecutive request-free cycles before an unfinished burst lock is released.

Ports:
- CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- req_ren  in  NUM_REQ  per-requester read request.
- req_wen  in  NUM_REQ  per-requester write request.
- req_addr  in  NUM_REQ*32  per-requester word address; slice i = bits [32i+31:32i].
- req_wdata  in  NUM_REQ*32  per-requester write data.
- req_byte_en  in  NUM_REQ*4  per-requester byte enables.
- req_busy  out  NUM_REQ  low for exactly the completing cycle of that requester's access.
- req_rdata  out  32  shared read data; valid only for the requester whose busy is low.
- mem_ren  out  1  read request to memory controller.
- mem_wen  out  1  write request to memory controller.
- mem_addr  out  32  forwarded address.
- mem_wdata  out  32  forwarded write data.
- mem_byte_en  out  4  forwarded byte enables.
- mem_busy  in  1  low = current memory access completes this cycle.
- mem_rdata  in  32  memory read data.
- grant_id  out  $clog2(NUM_REQ)  current owner (debug/statistics).
- grant_valid  out  1  high in GRANT state.

Behaviour:
- Bus protocol: requester holds ren/wen/addr/wdata stable until its busy is low for one cycle. ren and wen both high from one requester is illegal; treated as a read (wen ignored).
- Reset (RST high at CLK edge): state IDLE, grant_id 0, rr_ptr 0, word_cnt 0, idle_cnt 0. Outputs: mem_ren/mem_wen 0, mem_addr/wdata/byte_en 0, req_busy all 1, req_rdata 0, grant_valid 0. Reset mid-transaction abandons it with no completion to any requester; mem side drops its request the next cycle.
- FSM IDLE:
  - Outputs are reset values.
  - If any req_ren|req_wen is set, the winner is registered, next state is GRANT, word_cnt 0, idle_cnt 0.
  - Arbitration latency is 1 cycle; a request seen in IDLE is forwarded to memory no earlier than the next cycle.
- Winner selection:
  - ARB_MODE 0: first requesting index at or after rr_ptr, wrapping modulo NUM_REQ. rr_ptr <- winner+1 (mod NUM_REQ) when the grant is released.
  - ARB_MODE 1: lowest requesting index; rr_ptr unused.
- FSM GRANT (owner g):
  - mem_* combinationally forwards requester g's slice; mem_ren/mem_wen = g's ren/wen.
  - req_busy[g] = mem_busy when g requests, else 1. All other req_busy = 1.
  - req_rdata = mem_rdata.
- Completion (g requesting and mem_busy low):
  - word_cnt increments and idle_cnt clears.
  - When word_cnt reaches BLOCK_SIZE-1 at completion, the grant releases and next state is IDLE; word_cnt is width-safe, no wrap beyond BLOCK_SIZE-1.
- Idle cycles within a lock:
  - A cycle in GRANT with g not requesting increments idle_cnt.
  - When idle_cnt reaches IDLE_LIMIT-1 in such a cycle, the grant releases and next state is IDLE.
  - Partial bursts are therefore bounded.
- Other requesters' requests during GRANT are ignored, but remain pending with busy high; no request is ever dropped.
- Re-grant: back-to-back bursts pass through IDLE, so there is a 1-cycle bubble between owners. In round-robin, a continuously requesting owner is re-granted only if no other index requests.
- Starvation bound (round-robin): any requester is granted within (NUM_REQ-1) × (BLOCK_SIZE + IDLE_LIMIT + 1) burst-completion slots of memory service.
- BLOCK_SIZE=1: every completion releases the grant.

Test Plan:
- Reset, then requester 2 read of 0x0000_1000 with mem returning 0xDEADBEEF after 3 busy cycles → mem_ren rises the cycle after req, req_busy[2] low 1 cycle with req_rdata=0xDEADBEEF, state back to IDLE after the 2nd word only.
- NUM_REQ=4, ARB_MODE 0, all four requesting 2-word bursts simultaneously → grant order 0,1,2,3, each owning exactly 2 completions, 1-cycle bubble between owners, no interleaving.
- ARB_MODE 1, requesters 3 and 1 request together, then 0 arrives mid-burst of 1 → 1 finishes both words, then 0 granted, 3 last.
- Requester 0 completes word 1 then drops its request for 3 cycles (IDLE_LIMIT=3) → grant released on 3rd idle cycle; pending requester 1 granted next.
- Requester 1 write 0xCAFEF00D, byte_en 0xF, RST asserted while mem_busy high → next cycle mem_wen=0, req_busy all 1, grant_valid 0, rr_ptr=0.
- ren and wen both set on requester 0 → mem_ren=1, mem_wen=0.

Source files
------------

// File: rtl/coherent_mem_arbiter.sv
// coherent_mem_arbiter
//   Shares one memory-controller bus port between NUM_REQ coherency units.
//   A winner owns the bus for a burst of up to BLOCK_SIZE completed words, so
//   a line fill or writeback is never interleaved with another requester.
//   A lock is dropped early after IDLE_LIMIT consecutive cycles in which the
//   owner makes no request. Arbitration is round-robin (ARB_MODE 0) or fixed
//   priority with index 0 highest (ARB_MODE 1).
//
// Ports
//   CLK, RST         clock, synchronous active-high reset
//   req_ren/req_wen  per-requester read/write request (ren wins if both set)
//   req_addr/wdata   per-requester 32-bit slices, slice i = [32i+31:32i]
//   req_byte_en      per-requester 4-bit slices
//   req_busy         per-requester, low only in that requester's completing cycle
//   req_rdata        shared read data, meaningful for the requester whose busy is low
//   mem_*            forwarded request of the current owner
//   mem_busy         low when the current memory access completes
//   mem_rdata        memory read data
//   grant_id         current owner
//   grant_valid      high while a grant is held
//
// state    | meaning
// ST_IDLE  | no owner; pick a winner from the pending requests
// ST_GRANT | owner r_grant_id holds the bus until burst done or idle timeout

module coherent_mem_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int BLOCK_SIZE = 2,
  parameter int ARB_MODE   = 0,
  parameter int IDLE_LIMIT = 3
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic [NUM_REQ-1:0]         req_ren,
  input  logic [NUM_REQ-1:0]         req_wen,
  input  logic [NUM_REQ*32-1:0]      req_addr,
  input  logic [NUM_REQ*32-1:0]      req_wdata,
  input  logic [NUM_REQ*4-1:0]       req_byte_en,
  output logic [NUM_REQ-1:0]         req_busy,
  output logic [31:0]                req_rdata,
  output logic                       mem_ren,
  output logic                       mem_wen,
  output logic [31:0]                mem_addr,
  output logic [31:0]                mem_wdata,
  output logic [3:0]                 mem_byte_en,
  input  logic                       mem_busy,
  input  logic [31:0]                mem_rdata,
  output logic [$clog2(NUM_REQ)-1:0] grant_id,
  output logic                       grant_valid
);

  localparam int GW = $clog2(NUM_REQ);
  localparam int WW = (BLOCK_SIZE > 1) ? $clog2(BLOCK_SIZE) : 1;
  localparam int IW = (IDLE_LIMIT > 1) ? $clog2(IDLE_LIMIT) : 1;

  typedef enum logic {ST_IDLE, ST_GRANT} state_t;

  state_t          r_state;
  logic [GW-1:0]   r_grant_id;
  logic [GW-1:0]   r_rr_ptr;
  logic [WW-1:0]   r_word_cnt;
  logic [IW-1:0]   r_idle_cnt;

  logic [NUM_REQ-1:0] w_req;
  logic               w_own_req;
  logic [GW-1:0]      w_winner;
  logic               w_found;
  logic [GW:0]        w_sum;
  logic [GW-1:0]      w_idx;
  logic [GW-1:0]      w_next_ptr;
  logic [31:0]        w_addr  [NUM_REQ];
  logic [31:0]        w_wdata [NUM_REQ];
  logic [3:0]         w_be    [NUM_REQ];

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
    assign w_addr[gi]  = req_addr[32*gi +: 32];
    assign w_wdata[gi] = req_wdata[32*gi +: 32];
    assign w_be[gi]    = req_byte_en[4*gi +: 4];
  end

  assign w_req      = req_ren | req_wen;
  assign w_own_req  = w_req[r_grant_id];
  assign w_next_ptr = (r_grant_id == GW'(NUM_REQ-1)) ? '0 : r_grant_id + 1'b1;

  // Winner search. Round-robin scans from r_rr_ptr with an explicit wrap so
  // that non-power-of-two NUM_REQ works.
  always_comb begin
    w_winner = '0;
    w_found  = 1'b0;
    w_sum    = '0;
    w_idx    = '0;
    if (ARB_MODE == 1) begin
      for (int i = NUM_REQ-1; i >= 0; i--) begin
        if (w_req[i]) w_winner = GW'(i);
      end
    end else begin
      for (int k = 0; k < NUM_REQ; k++) begin
        w_sum = {1'b0, r_rr_ptr} + (GW+1)'(k);
        if (w_sum >= (GW+1)'(NUM_REQ)) w_sum = w_sum - (GW+1)'(NUM_REQ);
        w_idx = w_sum[GW-1:0];
        if (!w_found && w_req[w_idx]) begin
          w_winner = w_idx;
          w_found  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state    <= ST_IDLE;
      r_grant_id <= '0;
      r_rr_ptr   <= '0;
      r_word_cnt <= '0;
      r_idle_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (|w_req) begin
            r_grant_id <= w_winner;
            r_state    <= ST_GRANT;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
          end
        end
        ST_GRANT: begin
          if (w_own_req) begin
            // any owner activity breaks a run of quiet cycles
            r_idle_cnt <= '0;
            if (!mem_busy) begin
              if (r_word_cnt == WW'(BLOCK_SIZE-1)) begin
                r_state    <= ST_IDLE;
                r_rr_ptr   <= w_next_ptr;
                r_word_cnt <= '0;
              end else begin
                r_word_cnt <= r_word_cnt + 1'b1;
              end
            end
          end else if (r_idle_cnt == IW'(IDLE_LIMIT-1)) begin
            r_state    <= ST_IDLE;
            r_rr_ptr   <= w_next_ptr;
            r_word_cnt <= '0;
            r_idle_cnt <= '0;
          end else begin
            r_idle_cnt <= r_idle_cnt + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_ren     = 1'b0;
    mem_wen     = 1'b0;
    mem_addr    = '0;
    mem_wdata   = '0;
    mem_byte_en = '0;
    req_busy    = '1;
    req_rdata   = '0;
    if (r_state == ST_GRANT) begin
      mem_ren     = req_ren[r_grant_id];
      // a simultaneous ren+wen is treated as a read
      mem_wen     = req_wen[r_grant_id] & ~req_ren[r_grant_id];
      mem_addr    = w_addr[r_grant_id];
      mem_wdata   = w_wdata[r_grant_id];
      mem_byte_en = w_be[r_grant_id];
      req_busy[r_grant_id] = w_own_req ? mem_busy : 1'b1;
      req_rdata   = mem_rdata;
    end
  end

  assign grant_id    = r_grant_id;
  assign grant_valid = (r_state == ST_GRANT);

endmodule

// File: tb/tb_coherent_mem_arbiter.sv
// Two arbiters (round-robin and fixed priority) each with their own requester
// agents and memory responder, compared every cycle against a transaction-level
// model of ownership: who holds the bus, how many words it has completed in
// this lock, and how many consecutive cycles it has been quiet.

module tb_coherent_mem_arbiter;

  localparam int N  = 4;
  localparam int BS = 2;
  localparam int IL = 3;

  typedef struct {
    int          dly;
    bit          ren;
    bit          wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
  } txn_t;

  logic CLK = 1'b0;
  logic RST;

  logic [N-1:0]    ren   [2];
  logic [N-1:0]    wen   [2];
  logic [N*32-1:0] addr  [2];
  logic [N*32-1:0] wdata [2];
  logic [N*4-1:0]  be    [2];
  logic [N-1:0]    busy  [2];
  logic [31:0]     rdata [2];
  logic            mren  [2];
  logic            mwen  [2];
  logic [31:0]     maddr [2];
  logic [31:0]     mwdata[2];
  logic [3:0]      mbe   [2];
  logic            mbusy [2];
  logic [31:0]     mrdata[2];
  logic [1:0]      gid   [2];
  logic            gv    [2];

  for (genvar m = 0; m < 2; m++) begin : g_env
    coherent_mem_arbiter #(
      .NUM_REQ(N), .BLOCK_SIZE(BS), .ARB_MODE(m), .IDLE_LIMIT(IL)
    ) u_dut (
      .CLK(CLK), .RST(RST),
      .req_ren(ren[m]), .req_wen(wen[m]), .req_addr(addr[m]),
      .req_wdata(wdata[m]), .req_byte_en(be[m]),
      .req_busy(busy[m]), .req_rdata(rdata[m]),
      .mem_ren(mren[m]), .mem_wen(mwen[m]), .mem_addr(maddr[m]),
      .mem_wdata(mwdata[m]), .mem_byte_en(mbe[m]),
      .mem_busy(mbusy[m]), .mem_rdata(mrdata[m]),
      .grant_id(gid[m]), .grant_valid(gv[m])
    );
  end

  always #5 CLK = ~CLK;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) $display("FAIL %s: got %h expected %h", tag, got, exp);
    else n_pass++;
  endtask

  // reference model
  int own   [2];
  int ptr   [2];
  int words [2];
  int quiet [2];
  bit checking = 0;

  // agents
  txn_t q   [2][N][$];
  txn_t cur [2][N];
  bit   act [2][N];
  bit   comp[2][N];
  logic [31:0] last_rd [2][N];

  // memory responder
  int          lat_fix = -1;
  bit          data_fix_en = 0;
  logic [31:0] data_fix = '0;
  int          wait_c [2];
  bit          in_acc [2];
  bit          mreq_s [2];

  // observations
  int          gorder [2][$];
  bit          gv_prev[2];
  logic        snap_mwen[2];
  logic [31:0] snap_mwdata[2];
  logic [N-1:0] snap_busy[2];
  logic        snap_gv[2];
  bit          rw_seen[2];
  logic        rw_ren[2];
  logic        rw_wen[2];

  function automatic int pick(input int m, input logic [N-1:0] r);
    if (m == 1) begin
      for (int i = 0; i < N; i++) if (r[i]) return i;
    end else begin
      for (int k = 0; k < N; k++) if (r[(ptr[m] + k) % N]) return (ptr[m] + k) % N;
    end
    return -1;
  endfunction

  task automatic model_update(input int m);
    logic [N-1:0] r;
    bit rel;
    r   = ren[m] | wen[m];
    rel = 0;
    if (RST) begin
      own[m] = -1; ptr[m] = 0; words[m] = 0; quiet[m] = 0;
      checking = 1;
    end else if (own[m] < 0) begin
      if (r != 0) begin
        own[m] = pick(m, r); words[m] = 0; quiet[m] = 0;
      end
    end else begin
      if (r[own[m]]) begin
        quiet[m] = 0;
        if (!mbusy[m]) begin
          words[m]++;
          if (words[m] == BS) rel = 1;
        end
      end else begin
        quiet[m]++;
        if (quiet[m] == IL) rel = 1;
      end
      if (rel) begin
        ptr[m] = (own[m] + 1) % N;
        own[m] = -1;
      end
    end
  endtask

  task automatic check_env(input int m);
    logic [N-1:0] r, e_busy;
    logic e_ren, e_wen, e_gv;
    logic [31:0] e_addr, e_wd, e_rd;
    logic [3:0] e_be;
    int g;
    r = ren[m] | wen[m];
    e_ren = 0; e_wen = 0; e_gv = 0; e_addr = '0; e_wd = '0; e_rd = '0; e_be = '0;
    e_busy = '1;
    if (own[m] >= 0) begin
      g      = own[m];
      e_ren  = ren[m][g];
      e_wen  = wen[m][g] & ~ren[m][g];
      e_addr = addr[m][g*32 +: 32];
      e_wd   = wdata[m][g*32 +: 32];
      e_be   = be[m][g*4 +: 4];
      if (r[g]) e_busy[g] = mbusy[m];
      e_rd   = mrdata[m];
      e_gv   = 1;
      check_val($sformatf("m%0d_grant_id", m), 32'(gid[m]), 32'(g));
    end
    check_val($sformatf("m%0d_grant_valid", m), 32'(gv[m]), 32'(e_gv));
    check_val($sformatf("m%0d_mem_ren", m), 32'(mren[m]), 32'(e_ren));
    check_val($sformatf("m%0d_mem_wen", m), 32'(mwen[m]), 32'(e_wen));
    check_val($sformatf("m%0d_mem_addr", m), maddr[m], e_addr);
    check_val($sformatf("m%0d_mem_wdata", m), mwdata[m], e_wd);
    check_val($sformatf("m%0d_mem_byte_en", m), 32'(mbe[m]), 32'(e_be));
    check_val($sformatf("m%0d_req_busy", m), 32'(busy[m]), 32'(e_busy));
    check_val($sformatf("m%0d_req_rdata", m), rdata[m], e_rd);
  endtask

  task automatic step();
    txn_t t;
    bit   req;
    @(negedge CLK);
    for (int m = 0; m < 2; m++) begin
      if (checking) check_env(m);
      for (int i = 0; i < N; i++) begin
        comp[m][i] = !busy[m][i] && !RST;
        if (comp[m][i]) last_rd[m][i] = rdata[m];
      end
      mreq_s[m] = mren[m] | mwen[m];
      if (gv[m] && !gv_prev[m]) gorder[m].push_back(int'(gid[m]));
      gv_prev[m]     = gv[m];
      snap_mwen[m]   = mwen[m];
      snap_mwdata[m] = mwdata[m];
      snap_busy[m]   = busy[m];
      snap_gv[m]     = gv[m];
      if (gv[m] && gid[m] == 2'd0 && act[m][0] && cur[m][0].ren && cur[m][0].wen) begin
        rw_seen[m] = 1; rw_ren[m] = mren[m]; rw_wen[m] = mwen[m];
      end
    end
    @(posedge CLK);
    for (int m = 0; m < 2; m++) begin
      model_update(m);
      if (mreq_s[m]) begin
        if (wait_c[m] == 0) in_acc[m] = 0;
        else wait_c[m]--;
      end else in_acc[m] = 0;
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      for (int i = 0; i < N; i++) begin
        if (act[m][i] && comp[m][i]) act[m][i] = 0;
        comp[m][i] = 0;
        if (!act[m][i] && q[m][i].size() > 0) begin
          t = q[m][i][0];
          if (t.dly > 0) begin
            t.dly--;
            q[m][i][0] = t;
          end else begin
            cur[m][i] = q[m][i].pop_front();
            act[m][i] = 1;
          end
        end
        ren[m][i] = act[m][i] & cur[m][i].ren;
        wen[m][i] = act[m][i] & cur[m][i].wen;
        addr[m][i*32 +: 32]  = act[m][i] ? cur[m][i].addr  : $urandom;
        wdata[m][i*32 +: 32] = act[m][i] ? cur[m][i].wdata : $urandom;
        be[m][i*4 +: 4]      = act[m][i] ? cur[m][i].be    : 4'($urandom);
      end
    end
    #1;
    for (int m = 0; m < 2; m++) begin
      req = mren[m] | mwen[m];
      if (req) begin
        if (!in_acc[m]) begin
          in_acc[m] = 1;
          wait_c[m] = (lat_fix >= 0) ? lat_fix : int'($urandom_range(0, 3));
        end
        mbusy[m] = (wait_c[m] != 0);
      end else begin
        mbusy[m] = 1'($urandom_range(0, 1));
      end
      mrdata[m] = (data_fix_en && req && wait_c[m] == 0) ? data_fix : $urandom;
    end
  endtask

  task automatic push(input int i, input int dly, input bit r, input bit w,
                      input logic [31:0] a, input logic [31:0] d, input logic [3:0] b);
    txn_t t;
    t.dly = dly; t.ren = r; t.wen = w; t.addr = a; t.wdata = d; t.be = b;
    for (int m = 0; m < 2; m++) q[m][i].push_back(t);
  endtask

  function automatic bit all_idle();
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < N; i++)
        if (act[m][i] || q[m][i].size() != 0) return 0;
    return 1;
  endfunction

  task automatic drain(input string tag, input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin
      step();
      n++;
    end
    check_val({tag, "_drained"}, 32'(all_idle()), 32'd1);
  endtask

  task automatic do_reset();
    RST = 1; step(); step();
    RST = 0; step();
    for (int m = 0; m < 2; m++) gorder[m].delete();
  endtask

  task automatic check_order(input string tag, input int m, input int e0, input int e1,
                             input int e2, input int e3, input int len);
    int e [4];
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
    check_val($sformatf("%s_m%0d_len", tag, m), 32'(gorder[m].size()), 32'(len));
    for (int k = 0; k < len && k < gorder[m].size(); k++)
      check_val($sformatf("%s_m%0d_g%0d", tag, m, k), 32'(gorder[m][k]), 32'(e[k]));
  endtask

  initial begin
    int n;
    RST = 1;
    for (int m = 0; m < 2; m++) begin
      ren[m] = '0; wen[m] = '0; addr[m] = '0; wdata[m] = '0; be[m] = '0;
      mbusy[m] = 1; mrdata[m] = '0; own[m] = -1; ptr[m] = 0; words[m] = 0; quiet[m] = 0;
      wait_c[m] = 0; in_acc[m] = 0; mreq_s[m] = 0; gv_prev[m] = 0; rw_seen[m] = 0;
      rw_ren[m] = 0; rw_wen[m] = 0;
      for (int i = 0; i < N; i++) begin
        act[m][i] = 0; comp[m][i] = 0; last_rd[m][i] = '0;
      end
    end
    step();
    check_val("reset_gv", 32'(gv[0]), 32'd0);
    check_val("reset_busy", 32'(busy[0]), 32'hF);

    // single requester, two-word read, memory busy 3 cycles per word
    do_reset();
    lat_fix = 3; data_fix_en = 1; data_fix = 32'hDEADBEEF;
    push(2, 0, 1, 0, 32'h0000_1000, '0, 4'hF);
    push(2, 0, 1, 0, 32'h0000_1001, '0, 4'hF);
    drain("t1", 100);
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("t1_m%0d_rdata", m), last_rd[m][2], 32'hDEADBEEF);
      check_order("t1", m, 2, 0, 0, 0, 1);
    end
    data_fix_en = 0;

    // all four requesters, two-word bursts each
    do_reset();
    lat_fix = 0;
    for (int i = 0; i < N; i++)
      for (int w = 0; w < BS; w++) push(i, 0, 1, 0, 32'(i*16 + w), '0, 4'hF);
    drain("t2", 100);
    for (int m = 0; m < 2; m++) check_order("t2", m, 0, 1, 2, 3, 4);

    // 3 and 1 together, 0 arrives during 1's burst
    do_reset();
    for (int w = 0; w < BS; w++) begin
      push(3, 0, 1, 0, 32'h300 + 32'(w), '0, 4'hF);
      push(1, 0, 1, 0, 32'h100 + 32'(w), '0, 4'hF);
      push(0, (w == 0) ? 1 : 0, 1, 0, 32'h000 + 32'(w), '0, 4'hF);
    end
    drain("t3", 100);
    check_order("t3", 0, 1, 3, 0, 0, 3);
    check_order("t3", 1, 1, 0, 3, 0, 3);

    // owner goes quiet after one word, idle timeout hands bus to requester 1
    do_reset();
    push(0, 0, 1, 0, 32'h40, '0, 4'hF);
    push(0, 4, 1, 0, 32'h41, '0, 4'hF);
    push(1, 1, 0, 1, 32'h50, 32'h1234_5678, 4'h3);
    drain("t4", 100);
    for (int m = 0; m < 2; m++) check_order("t4", m, 0, 1, 0, 0, 3);

    // reset in the middle of a stalled write
    do_reset();
    lat_fix = 10;
    push(1, 0, 0, 1, 32'h60, 32'hCAFEF00D, 4'hF);
    n = 0;
    do begin
      step();
      n++;
    end while (!(snap_gv[0] && snap_gv[1]) && n < 20);
    check_val("t5_granted", 32'(snap_gv[0] & snap_gv[1]), 32'd1);
    check_val("t5_wdata", snap_mwdata[0], 32'hCAFEF00D);
    step(); step();
    RST = 1; step();
    RST = 0; step();
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("t5_m%0d_mem_wen", m), 32'(snap_mwen[m]), 32'd0);
      check_val($sformatf("t5_m%0d_busy", m), 32'(snap_busy[m]), 32'hF);
      check_val($sformatf("t5_m%0d_gv", m), 32'(snap_gv[m]), 32'd0);
    end
    lat_fix = 0;
    drain("t5", 100);

    // ren and wen together is a read
    do_reset();
    lat_fix = 1;
    push(0, 0, 1, 1, 32'h70, 32'hFFFF_0000, 4'hF);
    drain("t6", 100);
    for (int m = 0; m < 2; m++) begin
      check_val($sformatf("t6_m%0d_seen", m), 32'(rw_seen[m]), 32'd1);
      check_val($sformatf("t6_m%0d_ren", m), 32'(rw_ren[m]), 32'd1);
      check_val($sformatf("t6_m%0d_wen", m), 32'(rw_wen[m]), 32'd0);
    end

    // random traffic
    lat_fix = -1;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0 && q[0][i].size() < 3) begin
          int sel;
          sel = int'($urandom_range(0, 3));
          push(i, int'($urandom_range(0, 4)), sel != 1, sel == 1 || sel == 2,
               $urandom, $urandom, 4'($urandom));
        end
      end
      step();
    end
    drain("rand", 3000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
